// File: rtl/decoder_pkg.sv
// Shared encodings and helpers for ttl_decoder_ws.
// DECODER_TURNAROUND_EN adds the TURN state.
package decoder_pkg;

   localparam int MAX_WB    = 8;
   localparam int MAX_CFG_W = 256;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACTIVE = 2'd2
`ifdef DECODER_TURNAROUND_EN
      ,ST_TURN  = 2'd3
`endif
   } state_t;

   // Where a cycle end or abort lands: one forced all-high cycle, or straight back to IDLE.
`ifdef DECODER_TURNAROUND_EN
   localparam state_t ST_END = ST_TURN;
`else
   localparam state_t ST_END = ST_IDLE;
`endif

   // Field k of a packed per-output configuration vector, wb bits per field.
   function automatic logic [MAX_WB-1:0] wait_field(input logic [MAX_CFG_W-1:0] cfg,
                                                     input int unsigned k,
                                                     input int unsigned wb);
      logic [MAX_CFG_W-1:0] sh;
      sh = cfg >> (k * wb);
      return sh[MAX_WB-1:0] & ({MAX_WB{1'b1}} >> (MAX_WB - wb));
   endfunction

endpackage

// File: rtl/decoder_wait_counter.sv
// Wait-state down counter: loads once per cycle, counts down, flags the final wait cycle.
module decoder_wait_counter
   import decoder_pkg::*;
#(
   parameter int WAIT_BITS = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 load_i,
   input  logic [WAIT_BITS-1:0] load_val_i,
   input  logic                 dec_i,
   input  logic                 clr_i,
   output logic                 done_o
);

   logic [WAIT_BITS-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (clr_i)
         cnt_d = '0;
      else if (dec_i && cnt_q != '0)
         cnt_d = cnt_q - WAIT_BITS'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // High while the count is 1: the decrement at this edge is the last wait cycle.
   assign done_o = (cnt_q == WAIT_BITS'(1));

endmodule

// File: rtl/ttl_decoder_ws.sv
// Registered active-low decoder with per-output wait states driving CPU Ready.
// Optional DECODER_TURNAROUND_EN inserts one all-high cycle after each cycle end/abort.
module ttl_decoder_ws
   import decoder_pkg::*;
#(
   parameter int WIDTH      = 2,
   parameter int WAIT_BITS  = 2,
   parameter int DELAY_RISE = 20,
   parameter int DELAY_FALL = 20
) (
   input  logic                            Clk,
   input  logic                            Reset,
   input  logic                            Enable_n,
   input  logic [WIDTH-1:0]                A,
   input  logic [(2**WIDTH)*WAIT_BITS-1:0] Wait_cfg,
   output logic [2**WIDTH-1:0]             Y,
   output logic                            Ready
);

   localparam int NOUT = 2**WIDTH;

   // The delays describe board-level output timing; in this clocked model outputs
   // change only at the clock edge, so they are checked for sanity and otherwise unused.
   if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
      $error("ttl_decoder_ws: delays must be non-negative");
   end
   if (WAIT_BITS < 1 || WAIT_BITS > MAX_WB || NOUT * WAIT_BITS > MAX_CFG_W) begin : g_bad_cfg
      $error("ttl_decoder_ws: WIDTH/WAIT_BITS out of supported range");
   end

   state_t               state_q;
   logic [WIDTH-1:0]     sel_q;
   logic [NOUT-1:0]      y_q;
   logic                 ready_q;
   logic [WAIT_BITS-1:0] fld;
   logic                 cnt_load, cnt_dec, cnt_clr, cnt_done;

   assign fld = WAIT_BITS'(wait_field(MAX_CFG_W'(Wait_cfg), 32'(A), 32'(WAIT_BITS)));

   assign cnt_load = (state_q == ST_IDLE) && !Enable_n;
   assign cnt_dec  = (state_q == ST_WAIT) && !Enable_n;
   assign cnt_clr  = (state_q == ST_WAIT) &&  Enable_n;

   decoder_wait_counter #(.WAIT_BITS(WAIT_BITS)) u_wait_cnt (
      .clk_i      (Clk),
      .rst_i      (Reset),
      .load_i     (cnt_load),
      .load_val_i (fld),
      .dec_i      (cnt_dec),
      .clr_i      (cnt_clr),
      .done_o     (cnt_done)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         y_q     <= '1;
         ready_q <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!Enable_n) begin
                  sel_q <= A;
                  y_q   <= ~(NOUT'(1) << A);
                  if (fld == '0) begin
                     state_q <= ST_ACTIVE;
                  end else begin
                     state_q <= ST_WAIT;
                     ready_q <= 1'b0;
                  end
               end else begin
                  y_q     <= '1;
                  ready_q <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (Enable_n) begin
                  y_q     <= '1;
                  ready_q <= 1'b1;
                  state_q <= ST_END;
               end else if (cnt_done) begin
                  ready_q <= 1'b1;
                  state_q <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (Enable_n) begin
                  y_q     <= '1;
                  state_q <= ST_END;
               end
            end
`ifdef DECODER_TURNAROUND_EN
            ST_TURN: begin
               y_q     <= '1;
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end
`endif
            default: begin
               y_q     <= '1;
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign Y     = y_q;
   assign Ready = ready_q;

endmodule
